// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx -- serial pattern transmitter.
//
// A host loads a pattern (up to MAX_N bits), a length and a repeat count.
// The block sends the pattern one bit per clock, bit len-1 first and bit 0
// last, repeated load_rep+1 times. A detector loaded with the same pattern
// and length matches on the last bit of every frame.
//
// Optional feature macro: SEQ_TX_GAP_EN
//   defined   : GAP idle cycles are inserted between frames of one job.
//   undefined : frames are contiguous and parameter GAP is ignored.
//
// Ports:
//   clk, rst_n        clock (posedge) and synchronous active-low reset
//   load_valid/ready  job handshake; ready is high only while idle
//   load_pattern      pattern bits, bit len-1 is sent first
//   load_len          frame length in bits, clamped to MAX_N; 0 = empty job
//   load_rep          repeat count, frames sent = load_rep + 1
//   abort             cancels the job in progress (no done pulse)
//   data_out          serial bit, registered, 0 whenever no bit is sent
//   data_valid        data_out carries a pattern bit
//   frame_start/end   first / last bit of each frame
//   done              one-cycle pulse after the final bit of a job
module seq_pattern_tx #(
    parameter int MAX_N = 32,
    parameter int GAP   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [MAX_N-1:0]       load_pattern,
    input  logic [$clog2(MAX_N):0] load_len,
    input  logic [3:0]             load_rep,
    input  logic                   abort,
    output logic                   data_out,
    output logic                   data_valid,
    output logic                   frame_start,
    output logic                   frame_end,
    output logic                   done
);
    localparam int LEN_W = $clog2(MAX_N) + 1;
    localparam int IDX_W = $clog2(MAX_N);

`ifdef SEQ_TX_GAP_EN
    // Holds GAP-1 down to 0, so $clog2(GAP) bits are enough.
    localparam int GCNT_W = (GAP > 2) ? $clog2(GAP) : 1;
    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP, ST_FIN} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_FIN} state_t;
`endif

    state_t             state;
    logic [MAX_N-1:0]   pat_q;
    logic [IDX_W-1:0]   len_m1;
    logic [IDX_W-1:0]   idx;
    logic [3:0]         frm;
`ifdef SEQ_TX_GAP_EN
    logic [GCNT_W-1:0]  gcnt;
`endif

    logic [LEN_W-1:0]   len_c;
    logic [IDX_W-1:0]   first_idx;
    logic [IDX_W-1:0]   idx_dec;

    always_comb begin
        len_c     = (load_len > LEN_W'(MAX_N)) ? LEN_W'(MAX_N) : load_len;
        first_idx = IDX_W'(len_c - 1'b1);
        idx_dec   = idx - 1'b1;
    end

    // All outputs are registered: each edge computes what the next cycle
    // shows, so the bit emitted in a cycle is the one indexed by idx then.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            load_ready  <= 1'b1;
            data_out    <= 1'b0;
            data_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            done        <= 1'b0;
            idx         <= '0;
            frm         <= '0;
`ifdef SEQ_TX_GAP_EN
            gcnt        <= '0;
`endif
        end else begin
            data_out    <= 1'b0;
            data_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            done        <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (load_valid && load_ready) begin
                        pat_q      <= load_pattern;
                        frm        <= load_rep;
                        load_ready <= 1'b0;
                        if (len_c == '0) begin
                            state <= ST_FIN;
                            done  <= 1'b1;
                        end else begin
                            state       <= ST_SEND;
                            len_m1      <= first_idx;
                            idx         <= first_idx;
                            data_out    <= load_pattern[first_idx];
                            data_valid  <= 1'b1;
                            frame_start <= 1'b1;
                            frame_end   <= (first_idx == '0);
                        end
                    end
                end

                ST_SEND: begin
                    // Abort wins over frame completion on the same cycle.
                    if (abort) begin
                        state      <= ST_IDLE;
                        load_ready <= 1'b1;
                    end else if (idx != '0) begin
                        idx        <= idx_dec;
                        data_out   <= pat_q[idx_dec];
                        data_valid <= 1'b1;
                        frame_end  <= (idx_dec == '0);
                    end else if (frm != '0) begin
                        frm <= frm - 1'b1;
`ifdef SEQ_TX_GAP_EN
                        if (GAP > 0) begin
                            state <= ST_GAP;
                            gcnt  <= GCNT_W'(GAP - 1);
                        end else begin
                            idx         <= len_m1;
                            data_out    <= pat_q[len_m1];
                            data_valid  <= 1'b1;
                            frame_start <= 1'b1;
                            frame_end   <= (len_m1 == '0);
                        end
`else
                        idx         <= len_m1;
                        data_out    <= pat_q[len_m1];
                        data_valid  <= 1'b1;
                        frame_start <= 1'b1;
                        frame_end   <= (len_m1 == '0);
`endif
                    end else begin
                        state <= ST_FIN;
                        done  <= 1'b1;
                    end
                end

`ifdef SEQ_TX_GAP_EN
                ST_GAP: begin
                    if (abort) begin
                        state      <= ST_IDLE;
                        load_ready <= 1'b1;
                    end else if (gcnt == '0) begin
                        state       <= ST_SEND;
                        idx         <= len_m1;
                        data_out    <= pat_q[len_m1];
                        data_valid  <= 1'b1;
                        frame_start <= 1'b1;
                        frame_end   <= (len_m1 == '0);
                    end else begin
                        gcnt <= gcnt - 1'b1;
                    end
                end
`endif

                ST_FIN: begin
                    state      <= ST_IDLE;
                    load_ready <= 1'b1;
                end

                default: begin
                    state      <= ST_IDLE;
                    load_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_pattern_tx.sv
module tb_seq_pattern_tx;
    localparam int MAX_N = 32;
    localparam int GAP   = 2;
`ifdef SEQ_TX_GAP_EN
    localparam int G = GAP;
`else
    localparam int G = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_valid = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] load_pattern = '0;
    logic [5:0]  load_len = '0;
    logic [3:0]  load_rep = '0;
    logic        load_ready, data_out, data_valid, frame_start, frame_end, done;

    seq_pattern_tx #(.MAX_N(MAX_N), .GAP(GAP)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_pattern(load_pattern), .load_len(load_len), .load_rep(load_rep),
        .abort(abort),
        .data_out(data_out), .data_valid(data_valid),
        .frame_start(frame_start), .frame_end(frame_end), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic d;
        logic fs;
        logic fe;
        int   c;
    } item_t;

    item_t exp_q[$];
    int    done_q[$];
    int    n_checks = 0;
    int    n_pass = 0;
    bit    mon_en = 1'b0;

    task automatic check(input string name, input bit ok, input string info);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: %s", name, info);
    endtask

    // Reference model: expected bit stream of a job from its parameters.
    // Frame k, bit j appears at T+1 + k*(len+G) + j; done follows the last bit.
    function automatic void push_job(input int T, input logic [31:0] pat, input int len,
                                     input int rep, input int limit);
        int lc, n;
        item_t it;
        lc = (len > MAX_N) ? MAX_N : len;
        n = 0;
        for (int k = 0; k <= rep; k++) begin
            for (int j = 0; j < lc; j++) begin
                if (limit < 0 || n < limit) begin
                    it.d  = pat[lc-1-j];
                    it.fs = (j == 0);
                    it.fe = (j == lc-1);
                    it.c  = T + 1 + k*(lc+G) + j;
                    exp_q.push_back(it);
                end
                n++;
            end
        end
        if (limit < 0)
            done_q.push_back((lc == 0) ? T+1 : T + 1 + (rep+1)*lc + rep*G);
    endfunction

    // Monitor: pops expectations whenever the DUT presents a bit or done.
    always @(negedge clk) begin
        item_t e;
        int    dc;
        if (mon_en) begin
            if (data_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_bit", 1'b0, $sformatf("got bit at cyc %0d, want none", cyc));
                end else begin
                    e = exp_q.pop_front();
                    check("bit", data_out === e.d && frame_start === e.fs &&
                                 frame_end === e.fe && cyc == e.c,
                          $sformatf("got d=%0b fs=%0b fe=%0b cyc=%0d, want d=%0b fs=%0b fe=%0b cyc=%0d",
                                    data_out, frame_start, frame_end, cyc, e.d, e.fs, e.fe, e.c));
                end
            end else begin
                check("idle_zero", data_out === 1'b0 && frame_start === 1'b0 && frame_end === 1'b0,
                      $sformatf("got d=%0b fs=%0b fe=%0b at cyc %0d, want 0", data_out,
                                frame_start, frame_end, cyc));
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", 1'b0, $sformatf("got done at cyc %0d, want none", cyc));
                end else begin
                    dc = done_q.pop_front();
                    check("done_cycle", cyc == dc, $sformatf("got cyc %0d, want %0d", cyc, dc));
                end
            end
        end
    end

    // stop_bit > 0 ends the job on that (1-based) bit, by abort or by reset.
    task automatic do_job(input logic [31:0] pat, input int len, input int rep,
                          input int stop_bit, input bit use_reset, output int T);
        int lc, total, cstop, waited;
        lc = (len > MAX_N) ? MAX_N : len;
        total = lc * (rep + 1);
        load_pattern = pat;
        load_len = len[5:0];
        load_rep = rep[3:0];
        load_valid = 1'b1;
        waited = 0;
        T = -1;
        while (!load_ready && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        if (!load_ready) begin
            check("accept_timeout", 1'b0, "got load_ready=0 for 3000 cycles, want 1");
            load_valid = 1'b0;
            return;
        end
        T = cyc;
        cstop = -1;
        if (stop_bit > 0 && stop_bit <= total) begin
            push_job(T, pat, len, rep, use_reset ? -1 : stop_bit);
            cstop = T + 1 + ((stop_bit-1)/lc)*(lc+G) + (stop_bit-1)%lc;
        end else begin
            push_job(T, pat, len, rep, -1);
        end
        @(negedge clk);
        load_valid = 1'b0;
        if (cstop >= 0) begin
            while (cyc < cstop) @(negedge clk);
            if (use_reset) begin
                rst_n = 1'b0;
                #1;
                while (exp_q.size() > 0 && exp_q[$].c > cstop) void'(exp_q.pop_back());
                while (done_q.size() > 0 && done_q[$] > cstop) void'(done_q.pop_back());
                @(negedge clk);
                check("reset_mid_job", data_out === 1'b0 && data_valid === 1'b0 &&
                      frame_start === 1'b0 && frame_end === 1'b0 && done === 1'b0 &&
                      load_ready === 1'b1,
                      $sformatf("got d=%0b v=%0b fs=%0b fe=%0b done=%0b rdy=%0b, want 0 0 0 0 0 1",
                                data_out, data_valid, frame_start, frame_end, done, load_ready));
                rst_n = 1'b1;
            end else begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                check("abort_idle", data_valid === 1'b0 && done === 1'b0 && load_ready === 1'b1,
                      $sformatf("got v=%0b done=%0b rdy=%0b, want 0 0 1",
                                data_valid, done, load_ready));
            end
        end
    endtask

    initial begin
        int T, len, rep, stop, lc, waited;
        logic [31:0] pat;

        repeat (3) @(negedge clk);
        check("reset_values", data_out === 1'b0 && data_valid === 1'b0 && frame_start === 1'b0 &&
              frame_end === 1'b0 && done === 1'b0,
              $sformatf("got d=%0b v=%0b fs=%0b fe=%0b done=%0b, want all 0",
                        data_out, data_valid, frame_start, frame_end, done));
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", load_ready === 1'b1, $sformatf("got %0b, want 1", load_ready));
        mon_en = 1'b1;

        // Single frame 0xB, len 4: bits 1,0,1,1; done T+5; ready T+6.
        do_job(32'h0000000B, 4, 0, 0, 1'b0, T);
        check("ready_low_T1", load_ready === 1'b0, $sformatf("got %0b, want 0", load_ready));
        while (cyc < T + 5) @(negedge clk);
        check("ready_low_T5", load_ready === 1'b0, $sformatf("got %0b, want 0", load_ready));
        @(negedge clk);
        check("ready_high_T6", load_ready === 1'b1, $sformatf("got %0b, want 1", load_ready));

        // Three frames, clamp, zero length, len=1 repeated.
        do_job(32'h0000000B, 4, 2, 0, 1'b0, T);
        do_job(32'h80000001, 40, 0, 0, 1'b0, T);
        do_job(32'hFFFFFFFF, 0, 3, 0, 1'b0, T);
        do_job(32'h00000001, 1, 3, 0, 1'b0, T);

        // Abort on the 5th bit of a 16-bit job, then a new job at once.
        do_job(32'h0000A5C3, 16, 0, 5, 1'b0, T);
        do_job(32'h0000000B, 4, 0, 0, 1'b0, T);

        // Reset during frame 1 of a rep=3 job, then a fresh job.
        do_job(32'h0000002D, 6, 3, 9, 1'b1, T);
        do_job(32'h0000000B, 4, 1, 0, 1'b0, T);

        // Randomized jobs; load_valid stays high across back-to-back jobs.
        for (int i = 0; i < 40; i++) begin
            pat = $urandom;
            len = $urandom_range(0, 40);
            rep = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3);
            lc = (len > MAX_N) ? MAX_N : len;
            stop = 0;
            if (lc > 0 && $urandom_range(0, 4) == 0) stop = $urandom_range(1, lc*(rep+1));
            do_job(pat, len, rep, stop, 1'b0, T);
        end

        waited = 0;
        while ((exp_q.size() > 0 || done_q.size() > 0) && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        repeat (3) @(negedge clk);
        check("bits_drained", exp_q.size() == 0, $sformatf("got %0d pending bits, want 0", exp_q.size()));
        check("done_drained", done_q.size() == 0, $sformatf("got %0d pending done, want 0", done_q.size()));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/seq_pattern_tx.md
# seq_pattern_tx

Serial pattern transmitter: the transmit-side counterpart of the team's masked-compare sequence detector. A host loads an up-to-32-bit pattern, a length and a repeat count. The block then emits the pattern one bit per clock, oldest bit first, so that a detector programmed with the same pattern and length matches on the last bit of every frame. It sits between the pad/configuration logic and the serial data line that feeds the detector, and is used for loopback self-test and stimulus generation.

## Interface

Parameters:
- MAX_N, 32: maximum pattern length in bits; the length field is $clog2(MAX_N)+1 bits wide.
- GAP, 2: idle cycles inserted between frames; used only when SEQ_TX_GAP_EN is defined.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- load_valid  in  1  host offers a job.
- load_ready  out  1  block accepts a job; high only in IDLE.
- load_pattern  in  MAX_N  pattern; bit len-1 is sent first, bit 0 last.
- load_len  in  6  frame length in bits; valid range 1..MAX_N.
- load_rep  in  4  repeat count; frames sent = load_rep+1 (1..16).
- abort  in  1  cancels the job in progress.
- data_out  out  1  serial bit, registered.
- data_valid  out  1  data_out carries a pattern bit this cycle.
- frame_start  out  1  high with the first bit of each frame.
- frame_end  out  1  high with the last bit of each frame.
- done  out  1  one-cycle pulse after the final bit of a job.

## Operation

- States: IDLE, SEND, GAP (GAP exists only with SEQ_TX_GAP_EN), FIN.
- Job acceptance: a job is accepted on a cycle where load_valid && load_ready. On acceptance the block captures pattern, len and rep into shadow registers. Inputs are ignored at all other times.
- Length rules:
  - A len greater than MAX_N is clamped to MAX_N.
  - len = 0: the job is accepted, the block goes IDLE→FIN, done pulses, and no bits are sent.
- Counters:
  - Bit index counts from len-1 down to 0.
  - The frame counter counts down from rep.
- SEND:
  - Each cycle, data_out = pattern[idx] and data_valid = 1.
  - At idx = 0 with frames remaining: go to GAP, or straight back to SEND with idx reloaded when the gap is compiled out.
  - At idx = 0 on the last frame: go to FIN.
- GAP: holds for GAP cycles with data_out = 0 and data_valid = 0, then goes to SEND.
- FIN: done = 1 for one cycle, then IDLE.
- Abort:
  - abort = 1 in SEND or GAP: the next cycle is IDLE, data_valid = 0, and done is not pulsed. The partial frame is not completed.
  - abort in IDLE or FIN has no effect.
  - abort takes priority over frame completion in the same cycle.
- Outside SEND, data_out is held at 0.

## Timing

- Reset values: data_out=0, data_valid=0, frame_start=0, frame_end=0, done=0. State resets to IDLE, so load_ready=1 in the first cycle after reset is released.
- Acceptance at cycle T:
  - load_ready=0 from T+1.
  - First bit at T+1, with frame_start=1.
  - The last bit of frame k (k=0..rep) is at T+(k+1)·len+k·G, where G=GAP when SEQ_TX_GAP_EN is defined and G=0 otherwise.
- After the final bit at cycle L: done=1 at L+1 and load_ready=1 at L+2. A new job can be accepted at L+2.
- len=0 job: done at T+1, load_ready at T+2.
- len=1: frame_start and frame_end are both high in the same cycle.
- Back-to-back frames (no gap): frame_end of frame k and frame_start of frame k+1 are on consecutive cycles with no idle bit.
- Reset asserted mid-job takes priority over everything: all outputs take their reset values on the next edge, and the job is lost.

## Configuration

- SEQ_TX_GAP_EN, defined: the GAP state is built, and GAP idle cycles (data_valid=0, data_out=0) are inserted between consecutive frames of a job. No gap follows the last frame.
- SEQ_TX_GAP_EN, undefined: the GAP state and its counter are absent, frames are contiguous, and parameter GAP is ignored.

## Test plan

- Single frame: pattern=0x0000000B, len=4, rep=0, accepted at T.
  - data_out = 1,0,1,1 at T+1..T+4.
  - frame_start at T+1, frame_end at T+4, done at T+5, load_ready at T+6.
- Loopback: data_out feeds the detector programmed with 0x0B and len 4. The detector match rises exactly once per frame for rep=2, giving 3 pulses. With SEQ_TX_GAP_EN and GAP=2, frame 1's first bit is at T+7.
- Clamp and zero length:
  - len=40 sends 32 bits, MSB first, from pattern 0x80000001: first bit 1, then 30 zeros, then 1.
  - len=0: done at T+1, data_valid never high.
- Abort: in a 16-bit job, abort asserted on the 5th bit gives data_valid=0 on the next cycle, no done pulse, and load_ready=1. A new job loaded immediately starts cleanly.
- Reset mid-job: rst_n=0 during frame 1 of rep=3 forces all outputs to their reset values on the next edge. After release a fresh job transmits correctly.
- Handshake: load_valid held high during an active job is not accepted until load_ready=1. Exactly one acceptance occurs per load_valid&&load_ready cycle.
